// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, controller states, board type and start position.
package chess_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned POS_W  = 6;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned SQ_N   = 64;

  localparam logic [CODE_W-1:0] PC_EMPTY = CODE_W'(0);
  localparam logic [CODE_W-1:0] W_PAWN   = CODE_W'(1);
  localparam logic [CODE_W-1:0] W_ROOK   = CODE_W'(2);
  localparam logic [CODE_W-1:0] W_KNIGHT = CODE_W'(3);
  localparam logic [CODE_W-1:0] W_BISHOP = CODE_W'(4);
  localparam logic [CODE_W-1:0] W_QUEEN  = CODE_W'(5);
  localparam logic [CODE_W-1:0] W_KING   = CODE_W'(6);
  localparam logic [CODE_W-1:0] B_PAWN   = CODE_W'(7);
  localparam logic [CODE_W-1:0] B_ROOK   = CODE_W'(8);
  localparam logic [CODE_W-1:0] B_KNIGHT = CODE_W'(9);
  localparam logic [CODE_W-1:0] B_BISHOP = CODE_W'(10);
  localparam logic [CODE_W-1:0] B_QUEEN  = CODE_W'(11);
  localparam logic [CODE_W-1:0] B_KING   = CODE_W'(12);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MASK_WAIT,
    ST_WAIT_TARGET,
    ST_COMMIT
  } state_e;

  // board[row][col]; row 7 and column 7 are the most significant slices
  typedef logic [7:0][7:0][CODE_W-1:0] board_t;

  // Each row literal lists columns 7 down to 0
  localparam board_t START_BOARD = {
    B_ROOK, B_KNIGHT, B_BISHOP, B_KING, B_QUEEN, B_BISHOP, B_KNIGHT, B_ROOK,
    {8{B_PAWN}},
    {32{PC_EMPTY}},
    {8{W_PAWN}},
    W_ROOK, W_KNIGHT, W_BISHOP, W_KING, W_QUEEN, W_BISHOP, W_KNIGHT, W_ROOK
  };

  // True when the code belongs to the side currently to move
  function automatic logic is_own(input logic [CODE_W-1:0] code, input logic white);
    if (white) return (code >= W_PAWN) && (code <= W_KING);
    else       return (code >= B_PAWN) && (code <= B_KING);
  endfunction

endpackage

// File: rtl/board_store.sv
// 8x8 piece-code register array with a single commit port moving src to dst.
module board_store
  import chess_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [POS_W-1:0]  src_i,
  input  logic [POS_W-1:0]  dst_i,
  input  logic [CODE_W-1:0] code_i,
  output board_t            board_o
);

  board_t board_q;

  // Reset loads the start position; a commit clears src and overwrites dst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      board_q <= START_BOARD;
    end else if (we_i) begin
      board_q[src_i[5:3]][src_i[2:0]] <= PC_EMPTY;
      board_q[dst_i[5:3]][dst_i[2:0]] <= code_i;
    end
  end

  assign board_o = board_q;

endmodule

// File: rtl/move_commit_ctrl.sv
// Click-driven select/target/commit controller for a chess board.
// Optional feature: define PAWN_PROMOTION_EN to promote pawns reaching the last rank to queens.
module move_commit_ctrl
  import chess_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              click_valid,
  input  logic [POS_W-1:0]  click_pos,
  input  logic [SQ_N-1:0]   possible_moves,
  output logic [CODE_W-1:0] sel_figure,
  output logic [POS_W-1:0]  sel_pos,
  output board_t            board,
  output logic              white_turn,
  output logic              move_done,
  output logic              move_reject
);

  state_e              state_q, state_d;
  logic                cnt_q, cnt_d;
  logic [POS_W-1:0]    sel_pos_q, sel_pos_d;
  logic [CODE_W-1:0]   sel_fig_q, sel_fig_d;
  logic [POS_W-1:0]    dst_q, dst_d;
  logic                white_turn_q, white_turn_d;
  logic                move_done_q, move_done_d;
  logic                move_reject_q, move_reject_d;
  logic                wr_en_c;
  logic [CODE_W-1:0]   wr_code_c;
  logic [CODE_W-1:0]   click_code_c;
  logic                click_own_c;
  logic                mask_hit_c;

  board_store u_board (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (wr_en_c),
    .src_i   (sel_pos_q),
    .dst_i   (dst_q),
    .code_i  (wr_code_c),
    .board_o (board)
  );

  // Controller registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 1'b0;
      sel_pos_q     <= '0;
      sel_fig_q     <= PC_EMPTY;
      dst_q         <= '0;
      white_turn_q  <= 1'b1;
      move_done_q   <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_pos_q     <= sel_pos_d;
      sel_fig_q     <= sel_fig_d;
      dst_q         <= dst_d;
      white_turn_q  <= white_turn_d;
      move_done_q   <= move_done_d;
      move_reject_q <= move_reject_d;
    end
  end

  // Next-state, selection handling and commit control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_pos_d     = sel_pos_q;
    sel_fig_d     = sel_fig_q;
    dst_d         = dst_q;
    white_turn_d  = white_turn_q;
    move_done_d   = 1'b0;
    move_reject_d = 1'b0;
    wr_en_c       = 1'b0;
    wr_code_c     = sel_fig_q;
    click_code_c  = board[click_pos[5:3]][click_pos[2:0]];
    click_own_c   = is_own(click_code_c, white_turn_q);
    // Square (r,c) lives at bit 63-(r*8+c) of the mask
    mask_hit_c    = possible_moves[POS_W'(SQ_N - 1) - click_pos];

`ifdef PAWN_PROMOTION_EN
    if ((sel_fig_q == W_PAWN) && (dst_q[5:3] == ROW_W'(7))) begin
      wr_code_c = W_QUEEN;
    end else if ((sel_fig_q == B_PAWN) && (dst_q[5:3] == ROW_W'(0))) begin
      wr_code_c = B_QUEEN;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (click_valid && click_own_c) begin
          sel_pos_d = click_pos;
          sel_fig_d = click_code_c;
          cnt_d     = 1'b0;
          state_d   = ST_MASK_WAIT;
        end
      end
      ST_MASK_WAIT: begin
        // Two cycles for the mask producer to reflect the new selection
        if (cnt_q) state_d = ST_WAIT_TARGET;
        else       cnt_d   = 1'b1;
      end
      ST_WAIT_TARGET: begin
        if (click_valid) begin
          if (click_pos == sel_pos_q) begin
            sel_fig_d = PC_EMPTY;
            state_d   = ST_IDLE;
          end else if (click_own_c) begin
            sel_pos_d = click_pos;
            sel_fig_d = click_code_c;
            cnt_d     = 1'b0;
            state_d   = ST_MASK_WAIT;
          end else if (mask_hit_c) begin
            dst_d   = click_pos;
            state_d = ST_COMMIT;
          end else begin
            move_reject_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        wr_en_c      = 1'b1;
        white_turn_d = ~white_turn_q;
        move_done_d  = 1'b1;
        sel_fig_d    = PC_EMPTY;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel_figure  = sel_fig_q;
  assign sel_pos     = sel_pos_q;
  assign white_turn  = white_turn_q;
  assign move_done   = move_done_q;
  assign move_reject = move_reject_q;

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Directed bench for move_commit_ctrl: selection, rejection, reselection, commits, promotion, reset.
module tb_move_commit_ctrl;
  import chess_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        click_valid;
  logic [5:0]  click_pos;
  logic [63:0] possible_moves;
  logic [3:0]  sel_figure;
  logic [5:0]  sel_pos;
  board_t      board;
  logic        white_turn;
  logic        move_done;
  logic        move_reject;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_b [8][8];
  logic       exp_white;
  logic [3:0] promo_code;

  move_commit_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .click_valid    (click_valid),
    .click_pos      (click_pos),
    .possible_moves (possible_moves),
    .sel_figure     (sel_figure),
    .sel_pos        (sel_pos),
    .board          (board),
    .white_turn     (white_turn),
    .move_done      (move_done),
    .move_reject    (move_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] sq(input int r, input int c);
    return 6'(r * 8 + c);
  endfunction

  function automatic logic [63:0] bit_of(input int r, input int c);
    logic [63:0] m;
    m = '0;
    m[63 - (r * 8 + c)] = 1'b1;
    return m;
  endfunction

  function automatic board_t exp_board();
    board_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = exp_b[r][c];
    return b;
  endfunction

  task automatic load_start();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_b[r][c] = 4'd0;
    exp_b[0] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd4, 4'd3, 4'd2};
    exp_b[1] = '{default: 4'd1};
    exp_b[6] = '{default: 4'd7};
    exp_b[7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd10, 4'd9, 4'd8};
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic click(input logic [5:0] p);
    click_valid = 1'b1;
    click_pos   = p;
    @(negedge clk);
    click_valid = 1'b0;
  endtask

  task automatic check_state(input string tag, input state_e s);
    check(tag, 256'(dut.state_q), 256'(s));
  endtask

  // Full select / wait / target / commit sequence with the mask allowing only dst
  task automatic do_move(input string tag, input int sr, input int sc,
                         input int dr, input int dc, input logic [3:0] dst_code);
    possible_moves = bit_of(dr, dc);
    click(sq(sr, sc));
    idle(2);
    click(sq(dr, dc));
    check({tag, ":done_early"}, 256'(move_done), 256'(1'b0));
    idle(1);
    exp_b[dr][dc] = dst_code;
    exp_b[sr][sc] = 4'd0;
    exp_white     = ~exp_white;
    check({tag, ":done"}, 256'(move_done), 256'(1'b1));
    check({tag, ":board"}, 256'(board), 256'(exp_board()));
    check({tag, ":turn"}, 256'(white_turn), 256'(exp_white));
    check({tag, ":sel_clr"}, 256'(sel_figure), 256'(4'd0));
    idle(1);
    check({tag, ":done_pulse"}, 256'(move_done), 256'(1'b0));
  endtask

  initial begin
    rst            = 1'b0;
    click_valid    = 1'b0;
    click_pos      = '0;
    possible_moves = '0;
    load_start();
    exp_white = 1'b1;
`ifdef PAWN_PROMOTION_EN
    promo_code = 4'd5;
`else
    promo_code = 4'd1;
`endif
    idle(2);

    // Held in reset
    check("rst_board", 256'(board), 256'(exp_board()));
    check("rst_turn", 256'(white_turn), 256'(1'b1));
    check("rst_selfig", 256'(sel_figure), 256'(4'd0));
    check("rst_selpos", 256'(sel_pos), 256'(6'd0));
    check("rst_done", 256'(move_done), 256'(1'b0));
    check("rst_reject", 256'(move_reject), 256'(1'b0));
    check_state("rst_state", ST_IDLE);
    rst = 1'b1;
    idle(1);

    // White to move: black piece and empty square are ignored
    click(sq(6, 0));
    check("opp_click_selfig", 256'(sel_figure), 256'(4'd0));
    check_state("opp_click_state", ST_IDLE);
    click(sq(3, 3));
    check_state("empty_click_state", ST_IDLE);

    // Select (1,0), target outside the mask is rejected
    click(sq(1, 0));
    check("sel_pawn_fig", 256'(sel_figure), 256'(4'd1));
    check("sel_pawn_pos", 256'(sel_pos), 256'(sq(1, 0)));
    check_state("sel_pawn_state", ST_MASK_WAIT);
    idle(2);
    check_state("sel_pawn_wait", ST_WAIT_TARGET);
    possible_moves = bit_of(2, 0) | bit_of(3, 0);
    click(sq(4, 0));
    check("reject_pulse", 256'(move_reject), 256'(1'b1));
    check_state("reject_state", ST_WAIT_TARGET);
    check("reject_board", 256'(board), 256'(exp_board()));
    idle(1);
    check("reject_clear", 256'(move_reject), 256'(1'b0));

    // Reselect the knight at (0,1); mask wait lasts two cycles
    click(sq(0, 1));
    check("resel_fig", 256'(sel_figure), 256'(4'd3));
    check("resel_pos", 256'(sel_pos), 256'(sq(0, 1)));
    check_state("resel_mw1", ST_MASK_WAIT);
    idle(1);
    check_state("resel_mw2", ST_MASK_WAIT);
    idle(1);
    check_state("resel_wt", ST_WAIT_TARGET);

    // Click the selected square again: deselect, no pulses
    click(sq(0, 1));
    check("desel_fig", 256'(sel_figure), 256'(4'd0));
    check_state("desel_state", ST_IDLE);
    check("desel_done", 256'(move_done), 256'(1'b0));
    check("desel_reject", 256'(move_reject), 256'(1'b0));

    // e2-e4 style move; a click during mask wait is dropped
    possible_moves = bit_of(3, 4);
    click(sq(1, 4));
    idle(1);
    click(sq(3, 4));
    check_state("drop_state", ST_WAIT_TARGET);
    check("drop_board", 256'(board), 256'(exp_board()));
    check("drop_done", 256'(move_done), 256'(1'b0));
    click(sq(3, 4));
    check_state("commit_state", ST_COMMIT);
    idle(1);
    exp_b[3][4] = 4'd1;
    exp_b[1][4] = 4'd0;
    exp_white   = 1'b0;
    check("m1_done", 256'(move_done), 256'(1'b1));
    check("m1_dst", 256'(board[3][4]), 256'(4'd1));
    check("m1_src", 256'(board[1][4]), 256'(4'd0));
    check("m1_board", 256'(board), 256'(exp_board()));
    check("m1_turn", 256'(white_turn), 256'(1'b0));
    idle(1);
    check("m1_done_pulse", 256'(move_done), 256'(1'b0));
    check_state("m1_idle", ST_IDLE);

    // Bring the white pawn to (6,2) by capture, then onto the last rank
    do_move("m2", 6, 0, 5, 0, 4'd7);
    do_move("m3", 3, 4, 6, 2, 4'd1);
    do_move("m4", 7, 1, 5, 2, 4'd9);
    do_move("m5_promo", 6, 2, 7, 2, promo_code);
    check("promo_square", 256'(board[7][2]), 256'(promo_code));

    // Reset during mask wait restores everything
    click(sq(6, 1));
    check_state("pre_rst_state", ST_MASK_WAIT);
    rst = 1'b0;
    #1;
    load_start();
    exp_white = 1'b1;
    check("mid_rst_board", 256'(board), 256'(exp_board()));
    check("mid_rst_turn", 256'(white_turn), 256'(1'b1));
    check("mid_rst_selfig", 256'(sel_figure), 256'(4'd0));
    check("mid_rst_selpos", 256'(sel_pos), 256'(6'd0));
    check("mid_rst_done", 256'(move_done), 256'(1'b0));
    check("mid_rst_reject", 256'(move_reject), 256'(1'b0));
    check_state("mid_rst_state", ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // White selects normally again after reset
    click(sq(1, 4));
    check("post_rst_sel", 256'(sel_figure), 256'(4'd1));
    check_state("post_rst_state", ST_MASK_WAIT);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_commit_ctrl.md
MOVE_COMMIT_CTRL -- requirements
Module: move_commit_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: click_valid  input  1  one-cycle strobe; a square was clicked.
REQ-004 SHALL have port: click_pos  input  6  clicked square; [2:0] column 0-7, [5:3] row 0-7.
REQ-005 SHALL have port: possible_moves  input  64  legal-target mask for the selected piece; square (r,c) maps to bit 63-(r*8+c).
REQ-006 SHALL have port: sel_figure  output  4  code of the selected piece; 0 when nothing is selected.
REQ-007 SHALL have port: sel_pos  output  6  square of the selected piece.
REQ-008 SHALL have port: board  output  4x8x8  board[row][col] piece codes, registered.
REQ-009 SHALL have port: white_turn  output  1  1 = white to move.
REQ-010 SHALL have port: move_done  output  1  one-cycle pulse; a move was committed.
REQ-011 SHALL have port: move_reject  output  1  one-cycle pulse; the target was not in the mask.

Function
REQ-012 SHALL use piece codes: 0 empty; white 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king; black = white code + 6 (7-12).
REQ-013 SHALL classify own pieces: codes 1-6 when white_turn=1, codes 7-12 when white_turn=0.
REQ-014 SHALL implement an FSM with states IDLE, MASK_WAIT, WAIT_TARGET, COMMIT.
REQ-015 In IDLE, a click on an own piece SHALL latch sel_pos and sel_figure and move to MASK_WAIT; all other clicks are ignored.
REQ-016 MASK_WAIT SHALL last exactly 2 cycles, then move to WAIT_TARGET, to cover the registered latency of the mask producer.
REQ-017 SHALL sample possible_moves only when a click arrives in WAIT_TARGET.
REQ-018 In WAIT_TARGET, a click on sel_pos SHALL deselect: sel_figure=0, go to IDLE, no pulse.
REQ-019 In WAIT_TARGET, a click on another own piece SHALL reselect it and go to MASK_WAIT; this check takes priority over the mask.
REQ-020 In WAIT_TARGET, a click whose mask bit is 1 SHALL go to COMMIT.
REQ-021 In WAIT_TARGET, a click whose mask bit is 0 SHALL pulse move_reject for one cycle and remain in WAIT_TARGET.
REQ-022 COMMIT SHALL last 1 cycle and perform, in that cycle:
  - board[dst] <= moved piece code;
  - board[src] <= 0;
  - toggle white_turn;
  - pulse move_done;
  - sel_figure <= 0;
  - go to IDLE.
REQ-023 Clicks arriving during MASK_WAIT or COMMIT SHALL be ignored (dropped, not queued).
REQ-024 Board updates SHALL occur only in COMMIT; capture simply overwrites the destination code.

Reset
REQ-025 While rst=0 the block SHALL hold:
  - state IDLE;
  - white_turn=1;
  - sel_figure=0 and sel_pos=0;
  - move_done=0 and move_reject=0;
  - board at the standard start position.
REQ-026 Standard start position:
  - row 0 = 2,3,4,5,6,4,3,2 (columns 0-7); row 1 = 1;
  - row 6 = 7; row 7 = 8,9,10,11,12,10,9,8;
  - rows 2-5 = 0.
REQ-027 Reset asserted mid-move (any state) SHALL discard the move and restore the full reset state.

Configuration
REQ-028 SHALL provide macro PAWN_PROMOTION_EN.
REQ-029 With PAWN_PROMOTION_EN defined:
  - a white pawn (1) committed to row 7 SHALL be written as 5;
  - a black pawn (7) committed to row 0 SHALL be written as 11.
REQ-030 Without PAWN_PROMOTION_EN, the piece code SHALL be written unchanged.

Structure
REQ-031 Package chess_pkg SHALL hold the piece-code constants, the FSM state enum and the start-position constant.
REQ-032 Sub-module board_store SHALL hold the 8x8x4 register array:
  - reset loads the start position;
  - one commit port writes src and dst in the same cycle.

Verification
REQ-033 Reset, click (1,4), wait 3 cycles, mask bit for (3,4) set, click (3,4) -> move_done pulse, board[3][4]=1, board[1][4]=0, white_turn=0.
REQ-034 White to move, click (6,0) -> no state change, sel_figure stays 0.
REQ-035 Select (1,0), click (4,0) with its mask bit 0 -> move_reject pulse, state WAIT_TARGET, board unchanged.
REQ-036 Select (1,0), then click (0,1) -> sel_figure=3, sel_pos=(0,1), 2-cycle MASK_WAIT again.
REQ-037 White pawn at (6,2), commit to (7,2) -> board[7][2]=5 with PAWN_PROMOTION_EN, 1 without.
REQ-038 Assert rst in MASK_WAIT after one move -> start position restored, white_turn=1, no pulses.
